// File: rtl/pic_seq_ctrl.sv
// pic_seq_ctrl: fetch/decode/execute sequencer for the 12-bit accumulator CPU.
// Each instruction takes FETCH -> DECODE -> EXEC. Run, single-step and sleep
// are controlled from the bench/panel. All strobes except ram_oe come straight
// from flops loaded with the value for the state being entered. ram_oe is
// decoded from the state register and the IR register, so it also only moves
// after a clock edge or CLR.
module pic_seq_ctrl #(
    parameter int IR_W    = 12,
    parameter int F_W     = 5,
    parameter int STATE_W = 3
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               run,
    input  logic               step,
    input  logic [IR_W-1:0]    ir,
    input  logic               alu_z,
    output logic               rom_oe,
    output logic               ir_en,
    output logic               pc_en,
    output logic               pc_jump,
    output logic               ram_oe,
    output logic               ram_we,
    output logic               acc_en,
    output logic               acc_lit,
    output logic               skip,
    output logic               halted,
    output logic               instr_done,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SLEEP  = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   skip_q, skip_d;
    logic   step_q, run_q;
    logic   step_rise_s, run_rise_s;

    logic   is_nop_s, is_sleep_s, is_movwf_s, is_alu_s, is_decfsz_s;
    logic   is_movlw_s, is_goto_s, d_bit_s;

    logic   rom_oe_q, ir_en_q, pc_en_q, pc_jump_q, ram_we_q;
    logic   acc_en_q, acc_lit_q, halted_q, instr_done_q;
    logic   rom_oe_d, ir_en_d, pc_en_d, pc_jump_d, ram_we_d;
    logic   acc_en_d, acc_lit_d, halted_d, instr_done_d;
    logic   exec_entry_s, annul_s, ram_oe_s;

    assign step_rise_s = step & ~step_q;
    assign run_rise_s  = run & ~run_q;
    // A pending skip annuls whichever instruction is executed next.
    assign annul_s     = skip_q;

    // Instruction decode of the IR register contents.
    always_comb begin
        is_nop_s    = (ir == IR_W'(12'h000));
        is_sleep_s  = (ir == IR_W'(12'h003));
        is_movwf_s  = (ir[IR_W-1:F_W] == 7'b0000001);
        is_decfsz_s = (ir[IR_W-1:IR_W-6] == 6'b001011);
        is_movlw_s  = (ir[IR_W-1:IR_W-4] == 4'b1100);
        is_goto_s   = (ir[IR_W-1:IR_W-3] == 3'b101);
        d_bit_s     = ir[F_W];
        // Every other code with the top two bits clear is a file-register ALU op.
        is_alu_s    = (ir[IR_W-1:IR_W-2] == 2'b00) && !is_nop_s && !is_sleep_s && !is_movwf_s;
    end

    // Next-state and skip-flag logic of the sequencer.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end else if (step_rise_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                // An annulled DECFSZ must not re-arm skip.
                if (!annul_s && is_decfsz_s) begin
                    skip_d = alu_z;
                end else begin
                    skip_d = 1'b0;
                end
                if (!annul_s && is_sleep_s) begin
                    state_d = ST_SLEEP;
                end else if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SLEEP: begin
                if (run_rise_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_SLEEP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                skip_d  = 1'b0;
            end
        endcase
    end

    // Strobe values for the state about to be entered (loaded into output flops).
    always_comb begin
        exec_entry_s = (state_d == ST_EXEC);
        rom_oe_d     = (state_d == ST_FETCH);
        ir_en_d      = (state_d == ST_FETCH);
        pc_en_d      = exec_entry_s;
        instr_done_d = exec_entry_s;
        halted_d     = (state_d == ST_SLEEP);
        pc_jump_d    = exec_entry_s && !annul_s && is_goto_s;
        ram_we_d     = exec_entry_s && !annul_s && (is_movwf_s || (is_alu_s && d_bit_s));
        acc_en_d     = exec_entry_s && !annul_s && ((is_alu_s && !d_bit_s) || is_movlw_s);
        acc_lit_d    = exec_entry_s && !annul_s && is_movlw_s;
    end

    // File reads span DECODE and EXEC of ALU ops; driven from registered state and IR.
    always_comb begin
        if ((state_q == ST_DECODE) || (state_q == ST_EXEC)) begin
            ram_oe_s = is_alu_s;
        end else begin
            ram_oe_s = 1'b0;
        end
    end

    // State, skip flag, edge detectors and output strobe registers.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q      <= ST_IDLE;
            skip_q       <= 1'b0;
            step_q       <= 1'b0;
            run_q        <= 1'b0;
            rom_oe_q     <= 1'b0;
            ir_en_q      <= 1'b0;
            pc_en_q      <= 1'b0;
            pc_jump_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            acc_en_q     <= 1'b0;
            acc_lit_q    <= 1'b0;
            halted_q     <= 1'b0;
            instr_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            step_q       <= step;
            run_q        <= run;
            rom_oe_q     <= rom_oe_d;
            ir_en_q      <= ir_en_d;
            pc_en_q      <= pc_en_d;
            pc_jump_q    <= pc_jump_d;
            ram_we_q     <= ram_we_d;
            acc_en_q     <= acc_en_d;
            acc_lit_q    <= acc_lit_d;
            halted_q     <= halted_d;
            instr_done_q <= instr_done_d;
        end
    end

    assign rom_oe     = rom_oe_q;
    assign ir_en      = ir_en_q;
    assign pc_en      = pc_en_q;
    assign pc_jump    = pc_jump_q;
    assign ram_oe     = ram_oe_s;
    assign ram_we     = ram_we_q;
    assign acc_en     = acc_en_q;
    assign acc_lit    = acc_lit_q;
    assign skip       = skip_q;
    assign halted     = halted_q;
    assign instr_done = instr_done_q;
    assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_pic_seq_ctrl.sv
// tb_pic_seq_ctrl: scoreboard bench for the sequencer. The bench plays the
// ROM/IR: when ir_en is seen it loads the next program word into ir (with its
// alu_z value) and pushes the expected EXEC strobes; each instr_done pops one.
module tb_pic_seq_ctrl;

    logic        CLK = 1'b0;
    logic        CLR, run, step, alu_z;
    logic [11:0] ir;
    logic        rom_oe, ir_en, pc_en, pc_jump, ram_oe, ram_we, acc_en, acc_lit;
    logic        skip, halted, instr_done;
    logic [2:0]  state;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [12:0] prog[$];   // {alu_z, instruction} in execution order
    logic [5:0]  sb[$];     // {pc_en, ram_we, acc_en, acc_lit, pc_jump, skip}
    logic        m_skip = 1'b0;

    pic_seq_ctrl #(.IR_W(12), .F_W(5), .STATE_W(3)) dut (
        .CLK(CLK), .CLR(CLR), .run(run), .step(step), .ir(ir), .alu_z(alu_z),
        .rom_oe(rom_oe), .ir_en(ir_en), .pc_en(pc_en), .pc_jump(pc_jump),
        .ram_oe(ram_oe), .ram_we(ram_we), .acc_en(acc_en), .acc_lit(acc_lit),
        .skip(skip), .halted(halted), .instr_done(instr_done), .state(state)
    );

    always #5 CLK = ~CLK;

    function automatic logic is_alu(input logic [11:0] i);
        return (i[11:10] == 2'b00) && (i != 12'h000) && (i != 12'h003) && (i[11:5] != 7'b0000001);
    endfunction

    function automatic logic [5:0] exp_exec(input logic [11:0] i, input logic annul);
        logic movwf, alu, movlw, go, d;
        movwf = (i[11:5] == 7'b0000001);
        alu   = is_alu(i);
        movlw = (i[11:8] == 4'b1100);
        go    = (i[11:9] == 3'b101);
        d     = i[5];
        if (annul) return 6'b100001;
        return {1'b1, movwf | (alu & d), (alu & ~d) | movlw, movlw, go, 1'b0};
    endfunction

    task automatic load_next();
        logic [12:0] e;
        if (prog.size() > 0) e = prog.pop_front();
        else e = 13'd0;
        ir    = e[11:0];
        alu_z = e[12];
        sb.push_back(exp_exec(e[11:0], m_skip));
        if (!m_skip && (e[11:6] == 6'b001011)) m_skip = e[12];
        else m_skip = 1'b0;
    endtask

    // One clock: IR model loads after the edge, returns at the falling edge.
    task automatic adv();
        logic load;
        load = ir_en;
        @(posedge CLK);
        #1;
        if (load) load_next();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        CLR = 1'b0; run = 1'b0; step = 1'b0; alu_z = 1'b0; ir = 12'h000;
        @(negedge CLK); @(negedge CLK);
        n_cmp++;
        if ({rom_oe, ir_en, pc_en, pc_jump, ram_oe, ram_we, acc_en, acc_lit, skip, halted, instr_done, state} !== 14'd0) begin
            n_err++; $display("FAIL reset_outputs: got %b required all zero",
                {rom_oe, ir_en, pc_en, pc_jump, ram_oe, ram_we, acc_en, acc_lit, skip, halted, instr_done, state});
        end
        CLR = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_run_movlw();
        logic [5:0] got_v, exp_v;
        logic [2:0] es;
        logic       ed;
        repeat (4) prog.push_back({1'b0, 12'hC5A});
        run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 11) run = 1'b0;
            adv();
            if (instr_done) begin
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL run_exec: got extra instr_done, required none"); end
                else begin
                    exp_v = sb.pop_front(); got_v = {pc_en, ram_we, acc_en, acc_lit, pc_jump, skip};
                    if (got_v !== exp_v) begin n_err++; $display("FAIL run_exec: got %b required %b", got_v, exp_v); end
                end
            end
            es = 3'(((k - 1) % 3) + 1);
            ed = ((k % 3) == 0);
            n_cmp++;
            if (state !== es) begin n_err++; $display("FAIL run_state: cycle %0d got %0d required %0d", k, state, es); end
            n_cmp++;
            if (instr_done !== ed) begin n_err++; $display("FAIL run_done: cycle %0d got %b required %b", k, instr_done, ed); end
        end
        adv();
        n_cmp++;
        if ({state, 6'(sb.size())} !== 9'd0) begin n_err++; $display("FAIL run_stop: got state %0d pending %0d required 0/0", state, sb.size()); end
    endtask

    task automatic test_goto();
        logic [5:0] got_v, exp_v;
        prog.push_back({1'b0, 12'hBF0});
        prog.push_back({1'b0, 12'hC11});
        run = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            if (k == 5) run = 1'b0;
            adv();
            if (instr_done) begin
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL goto_exec: got extra instr_done, required none"); end
                else begin
                    exp_v = sb.pop_front(); got_v = {pc_en, ram_we, acc_en, acc_lit, pc_jump, skip};
                    if (got_v !== exp_v) begin n_err++; $display("FAIL goto_exec: got %b required %b", got_v, exp_v); end
                end
            end
            if (k == 4) begin
                n_cmp++;
                if ({state, pc_jump} !== {3'd1, 1'b0}) begin n_err++; $display("FAIL goto_refetch: got state %0d pc_jump %b required 1/0", state, pc_jump); end
            end
        end
        n_cmp++;
        if ({state, 6'(sb.size())} !== 9'd0) begin n_err++; $display("FAIL goto_stop: got state %0d pending %0d required 0/0", state, sb.size()); end
    endtask

    task automatic test_skip();
        logic [5:0] got_v, exp_v;
        prog.push_back({1'b1, 12'h2C3});  // DECFSZ 3,W  -> sets skip
        prog.push_back({1'b0, 12'h024});  // MOVWF 4     -> annulled
        prog.push_back({1'b0, 12'hC33});  // MOVLW
        prog.push_back({1'b1, 12'h2C3});  // DECFSZ      -> sets skip
        prog.push_back({1'b1, 12'h2E3});  // DECFSZ 3,F  -> annulled, no re-arm
        prog.push_back({1'b0, 12'hC44});  // MOVLW       -> executes
        prog.push_back({1'b0, 12'h2E3});  // DECFSZ z=0  -> writes file, no skip
        prog.push_back({1'b1, 12'h2C3});  // DECFSZ      -> sets skip
        prog.push_back({1'b0, 12'h003});  // SLEEP       -> annulled, no sleep
        prog.push_back({1'b0, 12'hC55});  // MOVLW
        run = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            if (k == 29) run = 1'b0;
            adv();
            if (instr_done) begin
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL skip_exec: got extra instr_done, required none"); end
                else begin
                    exp_v = sb.pop_front(); got_v = {pc_en, ram_we, acc_en, acc_lit, pc_jump, skip};
                    if (got_v !== exp_v) begin n_err++; $display("FAIL skip_exec: cycle %0d got %b required %b", k, got_v, exp_v); end
                end
            end
            if ((state == 3'd2) || (state == 3'd3)) begin
                n_cmp++;
                if (ram_oe !== is_alu(ir)) begin n_err++; $display("FAIL skip_ram_oe: cycle %0d got %b required %b", k, ram_oe, is_alu(ir)); end
            end
            n_cmp++;
            if (halted !== 1'b0) begin n_err++; $display("FAIL skip_no_sleep: cycle %0d got halted %b required 0", k, halted); end
        end
        n_cmp++;
        if ({state, skip, 6'(sb.size())} !== 10'd0) begin n_err++; $display("FAIL skip_stop: got state %0d skip %b pending %0d required 0/0/0", state, skip, sb.size()); end
    endtask

    task automatic test_step();
        logic [5:0] got_v, exp_v;
        int cnt = 0;
        prog.push_back({1'b0, 12'hC01});
        prog.push_back({1'b0, 12'hC02});
        run = 1'b0;
        for (int p = 0; p < 4; p++) begin
            step = (p % 2 == 0);
            repeat (10) begin
                adv();
                if (instr_done) begin
                    cnt++;
                    n_cmp++;
                    if (sb.size() == 0) begin n_err++; $display("FAIL step_exec: got extra instr_done, required none"); end
                    else begin
                        exp_v = sb.pop_front(); got_v = {pc_en, ram_we, acc_en, acc_lit, pc_jump, skip};
                        if (got_v !== exp_v) begin n_err++; $display("FAIL step_exec: got %b required %b", got_v, exp_v); end
                    end
                end
            end
            n_cmp++;
            if (state !== 3'd0) begin n_err++; $display("FAIL step_idle: phase %0d got state %0d required 0", p, state); end
        end
        n_cmp++;
        if (cnt !== 2) begin n_err++; $display("FAIL step_count: got %0d instr_done pulses required 2", cnt); end
    endtask

    task automatic test_sleep();
        logic [5:0] got_v, exp_v;
        prog.push_back({1'b0, 12'hC12});
        prog.push_back({1'b0, 12'h003});
        prog.push_back({1'b0, 12'hC77});
        run = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            adv();
            if (instr_done) begin
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL sleep_exec: got extra instr_done, required none"); end
                else begin
                    exp_v = sb.pop_front(); got_v = {pc_en, ram_we, acc_en, acc_lit, pc_jump, skip};
                    if (got_v !== exp_v) begin n_err++; $display("FAIL sleep_exec: got %b required %b", got_v, exp_v); end
                end
            end
        end
        for (int k = 0; k < 20; k++) begin
            n_cmp++;
            if ({halted, state, rom_oe, ir_en, pc_en, pc_jump, ram_oe, ram_we, acc_en, acc_lit, instr_done} !== {1'b1, 3'd4, 9'd0}) begin
                n_err++; $display("FAIL sleep_hold: cycle %0d got %b required %b", k,
                    {halted, state, rom_oe, ir_en, pc_en, pc_jump, ram_oe, ram_we, acc_en, acc_lit, instr_done}, {1'b1, 3'd4, 9'd0});
            end
            adv();
        end
        run = 1'b0;
        adv();
        n_cmp++;
        if ({halted, state} !== {1'b1, 3'd4}) begin n_err++; $display("FAIL sleep_run_low: got halted %b state %0d required 1/4", halted, state); end
        run = 1'b1;
        adv();
        n_cmp++;
        if ({halted, state, rom_oe} !== {1'b0, 3'd1, 1'b1}) begin n_err++; $display("FAIL sleep_wake: got halted %b state %0d rom_oe %b required 0/1/1", halted, state, rom_oe); end
        run = 1'b0;
        repeat (3) begin
            adv();
            if (instr_done) begin
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL wake_exec: got extra instr_done, required none"); end
                else begin
                    exp_v = sb.pop_front(); got_v = {pc_en, ram_we, acc_en, acc_lit, pc_jump, skip};
                    if (got_v !== exp_v) begin n_err++; $display("FAIL wake_exec: got %b required %b", got_v, exp_v); end
                end
            end
        end
        n_cmp++;
        if ({state, 6'(sb.size())} !== 9'd0) begin n_err++; $display("FAIL wake_stop: got state %0d pending %0d required 0/0", state, sb.size()); end
    endtask

    task automatic test_clr_exec();
        logic [5:0] got_v, exp_v;
        prog.push_back({1'b0, 12'h024});
        run = 1'b1;
        repeat (3) begin
            adv();
            if (instr_done) begin
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL clr_exec: got extra instr_done, required none"); end
                else begin
                    exp_v = sb.pop_front(); got_v = {pc_en, ram_we, acc_en, acc_lit, pc_jump, skip};
                    if (got_v !== exp_v) begin n_err++; $display("FAIL clr_exec: got %b required %b", got_v, exp_v); end
                end
            end
        end
        n_cmp++;
        if ({state, ram_we} !== {3'd3, 1'b1}) begin n_err++; $display("FAIL clr_pre: got state %0d ram_we %b required 3/1", state, ram_we); end
        run = 1'b0;
        #2 CLR = 1'b0;
        #1;
        n_cmp++;
        if ({state, ram_we, pc_en, instr_done} !== 6'd0) begin n_err++; $display("FAIL clr_async: got state %0d ram_we %b pc_en %b done %b required 0", state, ram_we, pc_en, instr_done); end
        sb.delete(); prog.delete(); m_skip = 1'b0; ir = 12'h000; alu_z = 1'b0;
        @(negedge CLK); @(negedge CLK);
        CLR = 1'b1;
        adv();
        n_cmp++;
        if ({rom_oe, ir_en, pc_en, pc_jump, ram_oe, ram_we, acc_en, acc_lit, skip, halted, instr_done, state} !== 14'd0) begin
            n_err++; $display("FAIL clr_release: got %b required all zero",
                {rom_oe, ir_en, pc_en, pc_jump, ram_oe, ram_we, acc_en, acc_lit, skip, halted, instr_done, state});
        end
    endtask

    initial begin
        test_reset();
        test_run_movlw();
        test_goto();
        test_skip();
        test_step();
        test_sleep();
        test_clr_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
